// File: rtl/regfile_sb_param.sv
// regfile_sb_param: register file with one write port, two async read ports,
// optional write bypass and zero register, and a per-register busy scoreboard.
module regfile_sb_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WR_addr,
    input  logic [DATA_W-1:0] WR_data,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    input  logic [ADDR_W-1:0] RA_addr,
    input  logic [ADDR_W-1:0] RB_addr,
    output logic [DATA_W-1:0] RA_data,
    output logic [DATA_W-1:0] RB_data,
    output logic              RA_busy,
    output logic              RB_busy,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_ok, lk_ok;
    logic              a_zero, b_zero, a_byp, b_byp;

    // Address 0 is inert when hard-wired to zero; nothing is forwarded during reset.
    assign wr_ok = WE && !rst && !(ZERO_REG != 0 && WR_addr == '0);
    assign lk_ok = lock_en && !(ZERO_REG != 0 && lock_addr == '0);

    always_comb begin
        busy_d = busy_q;
        if (wr_ok)
            busy_d[WR_addr] = 1'b0;
        if (lk_ok)
            busy_d[lock_addr] = 1'b1;
        cnt_d = '0;
        for (int i = 0; i < NREG; i++)
            cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok)
                regs_q[WR_addr] <= WR_data;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign a_zero = ZERO_REG != 0 && RA_addr == '0;
    assign b_zero = ZERO_REG != 0 && RB_addr == '0;
    assign a_byp  = BYPASS != 0 && wr_ok && WR_addr == RA_addr;
    assign b_byp  = BYPASS != 0 && wr_ok && WR_addr == RB_addr;

    assign RA_data  = a_zero ? '0 : a_byp ? WR_data : regs_q[RA_addr];
    assign RB_data  = b_zero ? '0 : b_byp ? WR_data : regs_q[RB_addr];
    assign RA_busy  = !a_zero && !a_byp && busy_q[RA_addr];
    assign RB_busy  = !b_zero && !b_byp && busy_q[RB_addr];
    assign busy_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_sb_param.sv
// tb_regfile_sb_param: drives a bypass instance and a zero-register/no-bypass
// instance with shared stimulus and checks both against an array model.
module tb_regfile_sb_param;
    localparam logic [1:0] ZR = 2'b10;
    localparam logic [1:0] BY = 2'b01;

    logic        clk = 1'b0, rst = 1'b1;
    logic        we = 1'b0, lock_en = 1'b0;
    logic [2:0]  wa = '0, la = '0, raa = '0, rba = '0;
    logic [15:0] wd = '0;
    logic [15:0] ra_d [2];
    logic [15:0] rb_d [2];
    logic        ra_b [2];
    logic        rb_b [2];
    logic [3:0]  cnt  [2];

    logic [15:0] m_reg  [2][8];
    bit          m_busy [2][8];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    regfile_sb_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .WE(we), .WR_addr(wa), .WR_data(wd),
        .lock_en(lock_en), .lock_addr(la), .RA_addr(raa), .RB_addr(rba),
        .RA_data(ra_d[0]), .RB_data(rb_d[0]), .RA_busy(ra_b[0]), .RB_busy(rb_b[0]),
        .busy_cnt(cnt[0]));

    regfile_sb_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_zero (
        .clk(clk), .rst(rst), .WE(we), .WR_addr(wa), .WR_data(wd),
        .lock_en(lock_en), .lock_addr(la), .RA_addr(raa), .RB_addr(rba),
        .RA_data(ra_d[1]), .RB_data(rb_d[1]), .RA_busy(ra_b[1]), .RB_busy(rb_b[1]),
        .busy_cnt(cnt[1]));

    function automatic logic [15:0] exp_rd(int k, logic [2:0] a);
        if (ZR[k] && a == 0) return 16'h0;
        if (BY[k] && we && !rst && wa == a) return wd;
        return m_reg[k][a];
    endfunction

    function automatic logic exp_bz(int k, logic [2:0] a);
        if (ZR[k] && a == 0) return 1'b0;
        if (BY[k] && we && !rst && wa == a) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic [3:0] exp_cnt(int k);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_busy[k][i]);
        return 4'(n);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i]  = '0;
                m_busy[k][i] = 1'b0;
            end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) clear_model();
        else
            for (int k = 0; k < 2; k++) begin
                if (we && !(ZR[k] && wa == 0)) begin
                    m_reg[k][wa]  = wd;
                    m_busy[k][wa] = 1'b0;
                end
                if (lock_en && !(ZR[k] && la == 0)) m_busy[k][la] = 1'b1;
            end
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; lock_en = 1'b0;
    endtask

    task automatic test_reset();
        clear_model();
        for (int i = 0; i < 4; i++) begin
            raa = 3'(i); rba = 3'(i + 4);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (ra_d[k] !== 16'h0 || rb_d[k] !== 16'h0) $display("FAIL reset_data%0d a%0d: got %h/%h want 0", k, i, ra_d[k], rb_d[k]); else n_pass++;
                n_chk++; if (ra_b[k] !== 1'b0 || rb_b[k] !== 1'b0 || cnt[k] !== 4'd0) $display("FAIL reset_busy%0d a%0d: got %b/%b cnt %0d want 0", k, i, ra_b[k], rb_b[k], cnt[k]); else n_pass++;
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rw();
        we = 1'b1; wa = 3'd3; wd = 16'hA5A5; step();
        wa = 3'd5; wd = 16'h1234; step();
        idle(); raa = 3'd3; rba = 3'd5; #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (ra_d[k] !== 16'hA5A5) $display("FAIL rw_ra%0d: got %h want a5a5", k, ra_d[k]); else n_pass++;
            n_chk++; if (rb_d[k] !== 16'h1234) $display("FAIL rw_rb%0d: got %h want 1234", k, rb_d[k]); else n_pass++;
        end
        raa = 3'd5; #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (ra_d[k] !== 16'h1234 || rb_d[k] !== 16'h1234) $display("FAIL rw_same%0d: got %h/%h want 1234", k, ra_d[k], rb_d[k]); else n_pass++;
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 3'd2; wd = 16'hBEEF; raa = 3'd2; rba = 3'd2; #1;
        n_chk++; if (ra_d[0] !== 16'hBEEF || rb_d[0] !== 16'hBEEF) $display("FAIL byp_pre: got %h/%h want beef", ra_d[0], rb_d[0]); else n_pass++;
        n_chk++; if (ra_d[1] !== 16'h0000) $display("FAIL nobyp_pre: got %h want 0000", ra_d[1]); else n_pass++;
        step(); idle(); #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (ra_d[k] !== 16'hBEEF) $display("FAIL byp_post%0d: got %h want beef", k, ra_d[k]); else n_pass++;
        end
    endtask

    task automatic test_lock();
        lock_en = 1'b1; la = 3'd4; raa = 3'd4; step(); idle(); #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (ra_b[k] !== 1'b1 || cnt[k] !== 4'd1) $display("FAIL lock%0d: got busy %b cnt %0d want 1/1", k, ra_b[k], cnt[k]); else n_pass++;
        end
        lock_en = 1'b1; we = 1'b1; wa = 3'd4; wd = 16'h5555; step(); idle(); #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (ra_b[k] !== 1'b1 || cnt[k] !== 4'd1 || ra_d[k] !== 16'h5555) $display("FAIL lockwr%0d: got busy %b cnt %0d data %h want 1/1/5555", k, ra_b[k], cnt[k], ra_d[k]); else n_pass++;
        end
        we = 1'b1; wd = 16'h6666; #1;
        n_chk++; if (ra_b[0] !== 1'b0) $display("FAIL byp_busy: got %b want 0", ra_b[0]); else n_pass++;
        n_chk++; if (ra_b[1] !== 1'b1) $display("FAIL nobyp_busy: got %b want 1", ra_b[1]); else n_pass++;
        step(); idle(); #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (ra_b[k] !== 1'b0 || cnt[k] !== 4'd0) $display("FAIL unlock%0d: got busy %b cnt %0d want 0/0", k, ra_b[k], cnt[k]); else n_pass++;
        end
    endtask

    task automatic test_zero();
        we = 1'b1; wa = 3'd0; wd = 16'hFFFF; lock_en = 1'b1; la = 3'd0; raa = 3'd0; step(); idle(); #1;
        n_chk++; if (ra_d[1] !== 16'h0 || ra_b[1] !== 1'b0 || cnt[1] !== 4'd0) $display("FAIL zero_r0: got %h busy %b cnt %0d want 0/0/0", ra_d[1], ra_b[1], cnt[1]); else n_pass++;
        n_chk++; if (ra_d[0] !== 16'hFFFF || ra_b[0] !== 1'b1 || cnt[0] !== 4'd1) $display("FAIL plain_r0: got %h busy %b cnt %0d want ffff/1/1", ra_d[0], ra_b[0], cnt[0]); else n_pass++;
        we = 1'b1; wa = 3'd0; wd = 16'h0; step(); idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            we = 1'($urandom); wa = 3'($urandom); wd = 16'($urandom);
            lock_en = 1'($urandom); la = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
            raa = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom);
            rba = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (ra_d[k] !== exp_rd(k, raa) || rb_d[k] !== exp_rd(k, rba)) $display("FAIL rand_data%0d c%0d: got %h/%h want %h/%h", k, c, ra_d[k], rb_d[k], exp_rd(k, raa), exp_rd(k, rba)); else n_pass++;
                n_chk++; if (ra_b[k] !== exp_bz(k, raa) || rb_b[k] !== exp_bz(k, rba)) $display("FAIL rand_busy%0d c%0d: got %b/%b want %b/%b", k, c, ra_b[k], rb_b[k], exp_bz(k, raa), exp_bz(k, rba)); else n_pass++;
                n_chk++; if (cnt[k] !== exp_cnt(k)) $display("FAIL rand_cnt%0d c%0d: got %0d want %0d", k, c, cnt[k], exp_cnt(k)); else n_pass++;
            end
            step();
        end
        idle();
    endtask

    task automatic test_ramp_reset();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wa = 3'(i); wd = 16'(i * 16'h1111); step();
        end
        idle();
        for (int i = 1; i < 8; i++) begin
            lock_en = 1'b1; la = 3'(i); step(); lock_en = 1'b0; #1;
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (cnt[k] !== 4'(i)) $display("FAIL ramp%0d step%0d: got %0d want %0d", k, i, cnt[k], i); else n_pass++;
            end
        end
        we = 1'b1; wa = 3'd3; wd = 16'h7777;
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            raa = 3'(i); rba = 3'(i + 4); #1;
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (ra_d[k] !== 16'h0 || rb_d[k] !== 16'h0 || ra_b[k] !== 1'b0 || rb_b[k] !== 1'b0 || cnt[k] !== 4'd0)
                    $display("FAIL async_rst%0d a%0d: got %h/%h busy %b/%b cnt %0d want all 0", k, i, ra_d[k], rb_d[k], ra_b[k], rb_b[k], cnt[k]); else n_pass++;
            end
        end
        clear_model();
        @(negedge clk);
        rst = 1'b0; idle(); raa = 3'd3; #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (ra_d[k] !== 16'h0 || cnt[k] !== 4'd0) $display("FAIL lost_write%0d: got %h cnt %0d want 0/0", k, ra_d[k], cnt[k]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_bypass();
        test_lock();
        test_zero();
        test_random();
        test_ramp_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
